// File: rtl/gate_cell_pkg.sv
// rtl/gate_cell_pkg.sv - cell mode encoding and single-bit cell evaluation
package gate_cell_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_INV   = 3'd0,
    MODE_NAND2 = 3'd1,
    MODE_NOR2  = 3'd2,
    MODE_AOI21 = 3'd3,
    MODE_OAI21 = 3'd4,
    MODE_BUF   = 3'd5,
    MODE_ZERO  = 3'd6,
    MODE_ONE   = 3'd7
  } mode_t;

  function automatic logic cell_eval(input mode_t mode, input logic a, input logic b,
                                     input logic c);
    logic r;
    case (mode)
      MODE_INV:   r = ~a;
      MODE_NAND2: r = ~(a & b);
      MODE_NOR2:  r = ~(a | b);
      MODE_AOI21: r = ~(a | (b & c));
      MODE_OAI21: r = ~(a & (b | c));
      MODE_BUF:   r = a;
      MODE_ZERO:  r = 1'b0;
      MODE_ONE:   r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_cell_slice.sv
// rtl/gate_cell_slice.sv - one channel's combinational mode-selected cell
module gate_cell_slice
  import gate_cell_pkg::*;
(
  input  mode_t mode,
  input  logic  a,
  input  logic  b,
  input  logic  c,
  output logic  y
);

  assign y = cell_eval(mode, a, b, c);

endmodule

// File: rtl/gate_array_cfg.sv
// rtl/gate_array_cfg.sv - registered array of run-time configurable 3-input cells
module gate_array_cfg
  import gate_cell_pkg::*;
#(
  parameter int                CH       = 8,
  parameter logic [MODE_W-1:0] RST_MODE = 3'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic          cfg_sin,
  output logic          cfg_sout,
  output logic          cfg_done,
  output logic          cfg_err,
  input  logic          err_clr,
  input  logic          valid_in,
  input  logic [CH-1:0] a,
  input  logic [CH-1:0] b,
  input  logic [CH-1:0] c,
  output logic [CH-1:0] y,
  output logic          valid_out
);

  localparam int N  = MODE_W * CH;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_SAT  = CW'(N + 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t          state;
  logic [N-1:0]    shadow;
  logic [N-1:0]    active;
  logic [CW-1:0]   count;
  logic [CH-1:0]   f;
  logic            accept;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    gate_cell_slice u_cell (
      .mode (mode_t'(active[MODE_W*i +: MODE_W])),
      .a    (a[i]),
      .b    (b[i]),
      .c    (c[i]),
      .y    (f[i])
    );
  end

  assign cfg_sout = shadow[N-1];
  // The commit cycle (SHIFT with cfg_en low) also drops data.
  assign accept   = valid_in && (state == ST_IDLE) && !cfg_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      active    <= {CH{RST_MODE}};
      count     <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      y         <= '0;
      valid_out <= 1'b0;
    end else begin
      cfg_done  <= 1'b0;
      valid_out <= accept;
      if (accept) y <= f;
      if (err_clr) cfg_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cfg_en) begin
            shadow <= {shadow[N-2:0], cfg_sin};
            count  <= CW'(1);
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cfg_en) begin
            shadow <= {shadow[N-2:0], cfg_sin};
            if (count != CNT_SAT) count <= count + CW'(1);
          end else begin
            if (count == CNT_FULL) begin
              active   <= shadow;
              cfg_done <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
            count <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
